// File: rtl/sb_rx_disp_pkg.sv
// Shared types and constants for the sideband RX message dispatcher.
package sb_rx_disp_pkg;

  // One decoded sideband message as stored in the FIFO and the output register.
  typedef struct packed {
    logic [3:0]  msg_no;
    logic [2:0]  msg_info;
    logic [15:0] data;
  } sb_rx_msg_t;

  typedef enum logic {
    IDLE    = 1'b0,
    PRESENT = 1'b1
  } disp_state_e;

  localparam logic [3:0] ADP_MSG_BASE_DEF = 4'd12;
  localparam int         DROP_CNT_W       = 8;

  // Message numbers at or above the base belong to the adapter.
  function automatic logic is_adp(input logic [3:0] msg_no, input logic [3:0] base);
    return msg_no >= base;
  endfunction

endpackage

// File: rtl/sb_rx_msg_fifo.sv
// Synchronous FIFO of decoded sideband messages. Head entry is always visible
// on rdata; pointers carry an extra MSB to tell full from empty.
module sb_rx_msg_fifo
  import sb_rx_disp_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  logic       pop,
  input  logic       flush,
  input  sb_rx_msg_t wdata,
  output sb_rx_msg_t rdata,
  output logic       full,
  output logic       empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  sb_rx_msg_t  mem [DEPTH];

  // Pointer update; flush wins over any push/pop in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (AW + 1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (AW + 1)'(1);
    end
  end

  // Storage write.
  always_ff @(posedge clk) begin
    // NOTE: the storage array has no reset; the pointers alone define which
    // entries are valid, so clearing the data would only cost flops.
    if (push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

  assign rdata = mem[rd_ptr[AW-1:0]];
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/sb_rx_msg_dispatcher.sv
// Sideband RX message dispatcher: buffers decoded messages, routes them to the
// LTSM or the adapter by message number, and counts dropped messages.
// Optional feature macro: SB_RX_DISP_TIMEOUT_EN enables the ready timeout.
module sb_rx_msg_dispatcher
  import sb_rx_disp_pkg::*;
#(
  parameter int         DEPTH          = 4,
  parameter logic [3:0] ADP_MSG_BASE   = ADP_MSG_BASE_DEF,
  parameter int         TIMEOUT_CYCLES = 64
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_msg_valid,
  input  logic                  i_parity_error,
  input  logic [3:0]            i_msg_no,
  input  logic [2:0]            i_msg_info,
  input  logic [15:0]           i_data,
  input  logic                  i_flush,
  output logic                  o_ltsm_valid,
  input  logic                  i_ltsm_ready,
  output logic                  o_adp_valid,
  input  logic                  i_adp_ready,
  output logic [3:0]            o_msg_no,
  output logic [2:0]            o_msg_info,
  output logic [15:0]           o_data,
  output logic                  o_overflow,
  output logic                  o_parity_drop,
  output logic                  o_timeout,
  output logic [DROP_CNT_W-1:0] o_drop_cnt
);

  // Elaboration-time parameter sanity checks.
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("sb_rx_msg_dispatcher: DEPTH must be a power of two >= 2");
  end
  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("sb_rx_msg_dispatcher: TIMEOUT_CYCLES must be >= 2");
  end

  disp_state_e state;
  disp_state_e state_nxt;
  sb_rx_msg_t  out_msg;
  sb_rx_msg_t  fifo_rdata;
  sb_rx_msg_t  in_msg;
  logic        fifo_full;
  logic        fifo_empty;
  logic        pop;
  logic        push;
  logic        push_req;
  logic        sel_adp;
  logic        sel_ready;
  logic        overflow_ev;
  logic        parity_ev;
  logic        timeout_ev;

  assign in_msg = '{msg_no: i_msg_no, msg_info: i_msg_info, data: i_data};

  // A message arriving during flush is discarded silently.
  assign push_req    = i_msg_valid & ~i_parity_error & ~i_flush;
  assign push        = push_req & (~fifo_full | pop);
  assign overflow_ev = push_req & fifo_full & ~pop;
  assign parity_ev   = i_msg_valid & i_parity_error & ~i_flush;

  assign sel_adp   = is_adp(out_msg.msg_no, ADP_MSG_BASE);
  assign sel_ready = sel_adp ? i_adp_ready : i_ltsm_ready;

  sb_rx_msg_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (i_clk),
    .rst_n (i_rst_n),
    .push  (push),
    .pop   (pop),
    .flush (i_flush),
    .wdata (in_msg),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // FSM state register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next state and FIFO pop; ready beats a timeout in the same cycle.
  always_comb begin
    // NOTE: defaults first so every path assigns every output -- no latches.
    state_nxt = state;
    pop       = 1'b0;
    if (i_flush) begin
      state_nxt = IDLE;
    end else begin
      unique case (state)
        IDLE: begin
          if (!fifo_empty) begin
            pop       = 1'b1;
            state_nxt = PRESENT;
          end
        end
        PRESENT: begin
          if (sel_ready) begin
            if (!fifo_empty) pop       = 1'b1;
            else             state_nxt = IDLE;
          end else if (timeout_ev) begin
            state_nxt = IDLE;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // FSM outputs: route the presented message to exactly one consumer.
  always_comb begin
    o_ltsm_valid = 1'b0;
    o_adp_valid  = 1'b0;
    if (state == PRESENT) begin
      o_ltsm_valid = ~sel_adp;
      o_adp_valid  = sel_adp;
    end
  end

  // Output register; only loads on a pop, so fields hold under backpressure.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)  out_msg <= '0;
    else if (pop)  out_msg <= fifo_rdata;
  end

  assign o_msg_no   = out_msg.msg_no;
  assign o_msg_info = out_msg.msg_info;
  assign o_data     = out_msg.data;

`ifdef SB_RX_DISP_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES);

  logic [TW-1:0] tmo_cnt;

  assign timeout_ev = (state == PRESENT) & ~sel_ready & ~i_flush &
                      (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));

  // Wait counter: restarts on every new presentation, counts stalled cycles.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)                          tmo_cnt <= '0;
    else if (i_flush || pop || timeout_ev) tmo_cnt <= '0;
    else if (state == PRESENT && !sel_ready) tmo_cnt <= tmo_cnt + TW'(1);
  end
`else
  assign timeout_ev = 1'b0;
`endif

  // Registered drop pulses and saturating drop counter (one step per cycle).
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_overflow    <= 1'b0;
      o_parity_drop <= 1'b0;
      o_timeout     <= 1'b0;
      o_drop_cnt    <= '0;
    end else begin
      o_overflow    <= overflow_ev;
      o_parity_drop <= parity_ev;
      o_timeout     <= timeout_ev;
      if ((overflow_ev || parity_ev || timeout_ev) && (o_drop_cnt != '1))
        o_drop_cnt <= o_drop_cnt + DROP_CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_sb_rx_msg_dispatcher.sv
// Directed self-checking bench for sb_rx_msg_dispatcher (DEPTH=4,
// ADP_MSG_BASE=12, TIMEOUT_CYCLES=8).
module tb_sb_rx_msg_dispatcher;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_msg_valid = 1'b0;
  logic        i_parity_error = 1'b0;
  logic [3:0]  i_msg_no = '0;
  logic [2:0]  i_msg_info = '0;
  logic [15:0] i_data = '0;
  logic        i_flush = 1'b0;
  logic        o_ltsm_valid;
  logic        i_ltsm_ready = 1'b0;
  logic        o_adp_valid;
  logic        i_adp_ready = 1'b0;
  logic [3:0]  o_msg_no;
  logic [2:0]  o_msg_info;
  logic [15:0] o_data;
  logic        o_overflow;
  logic        o_parity_drop;
  logic        o_timeout;
  logic [7:0]  o_drop_cnt;

  int tests = 0;
  int fails = 0;

  sb_rx_msg_dispatcher #(
    .DEPTH          (4),
    .ADP_MSG_BASE   (4'd12),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .i_clk          (i_clk),
    .i_rst_n        (i_rst_n),
    .i_msg_valid    (i_msg_valid),
    .i_parity_error (i_parity_error),
    .i_msg_no       (i_msg_no),
    .i_msg_info     (i_msg_info),
    .i_data         (i_data),
    .i_flush        (i_flush),
    .o_ltsm_valid   (o_ltsm_valid),
    .i_ltsm_ready   (i_ltsm_ready),
    .o_adp_valid    (o_adp_valid),
    .i_adp_ready    (i_adp_ready),
    .o_msg_no       (o_msg_no),
    .o_msg_info     (o_msg_info),
    .o_data         (o_data),
    .o_overflow     (o_overflow),
    .o_parity_drop  (o_parity_drop),
    .o_timeout      (o_timeout),
    .o_drop_cnt     (o_drop_cnt)
  );

  always #5 i_clk = ~i_clk;

  // Advance one clock; outputs are sampled and inputs driven 1 ns after the edge.
  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic do_reset();
    i_rst_n        = 1'b0;
    i_msg_valid    = 1'b0;
    i_parity_error = 1'b0;
    i_flush        = 1'b0;
    i_ltsm_ready   = 1'b0;
    i_adp_ready    = 1'b0;
    repeat (2) tick();
    i_rst_n = 1'b1;
    tick();
  endtask

  // Drive one message for one cycle; returns 1 ns after the capturing edge.
  task automatic send(input logic [3:0] no, input logic [2:0] info,
                      input logic [15:0] d, input logic par);
    i_msg_valid    = 1'b1;
    i_parity_error = par;
    i_msg_no       = no;
    i_msg_info     = info;
    i_data         = d;
    tick();
    i_msg_valid    = 1'b0;
    i_parity_error = 1'b0;
  endtask

  function automatic logic [30:0] all_outs();
    return {o_ltsm_valid, o_adp_valid, o_msg_no, o_msg_info, o_data,
            o_overflow, o_parity_drop, o_timeout};
  endfunction

  task automatic test_reset();
    i_rst_n = 1'b0;
    #1;
    tests++;
    if (all_outs() !== 31'd0 || o_drop_cnt !== 8'd0) begin
      fails++;
      $display("FAIL reset_in: outs=%h cnt=%0d, required 0/0", all_outs(), o_drop_cnt);
    end
    do_reset();
    tests++;
    if (all_outs() !== 31'd0 || o_drop_cnt !== 8'd0) begin
      fails++;
      $display("FAIL reset_after: outs=%h cnt=%0d, required 0/0", all_outs(), o_drop_cnt);
    end
  endtask

  task automatic test_single();
    i_ltsm_ready = 1'b1;
    send(4'd3, 3'd2, 16'hA5A5, 1'b0);
    tests++;
    if (o_ltsm_valid !== 1'b0) begin
      fails++;
      $display("FAIL single_n1: ltsm_valid=%b, required 0", o_ltsm_valid);
    end
    tick();
    tests++;
    if (o_ltsm_valid !== 1'b1 || o_adp_valid !== 1'b0 || o_msg_no !== 4'd3 ||
        o_msg_info !== 3'd2 || o_data !== 16'hA5A5) begin
      fails++;
      $display("FAIL single_n2: lv=%b av=%b no=%0d info=%0d data=%h, required 1 0 3 2 a5a5",
               o_ltsm_valid, o_adp_valid, o_msg_no, o_msg_info, o_data);
    end
    tick();
    tests++;
    if (o_ltsm_valid !== 1'b0 || o_adp_valid !== 1'b0) begin
      fails++;
      $display("FAIL single_done: lv=%b av=%b, required 0 0", o_ltsm_valid, o_adp_valid);
    end
    i_ltsm_ready = 1'b0;
  endtask

  task automatic test_adp_backpressure();
    int bad = 0;
    i_adp_ready = 1'b0;
    send(4'd13, 3'd5, 16'h1234, 1'b0);
    tick();
    for (int k = 0; k < 5; k++) begin
      if (o_adp_valid !== 1'b1 || o_ltsm_valid !== 1'b0 || o_msg_no !== 4'd13 ||
          o_msg_info !== 3'd5 || o_data !== 16'h1234) bad++;
      if (k < 4) tick();
    end
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL adp_hold: %0d unstable/invalid cycles, required 0", bad);
    end
    i_adp_ready = 1'b1;
    tick();
    tests++;
    if (o_adp_valid !== 1'b0) begin
      fails++;
      $display("FAIL adp_xfer: adp_valid=%b, required 0", o_adp_valid);
    end
    i_adp_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    int bad = 0;
    i_ltsm_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      i_msg_valid = 1'b1;
      i_msg_no    = 4'(k + 1);
      i_msg_info  = 3'd0;
      i_data      = 16'hB000 + 16'(k);
      tick();
      if (k > 0 && (o_ltsm_valid !== 1'b1 || o_data !== 16'hB000 + 16'(k - 1))) bad++;
    end
    i_msg_valid = 1'b0;
    tick();
    if (o_ltsm_valid !== 1'b1 || o_data !== 16'hB002) bad++;
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL b2b_stream: %0d wrong cycles, required 0", bad);
    end
    tick();
    tests++;
    if (o_ltsm_valid !== 1'b0) begin
      fails++;
      $display("FAIL b2b_end: ltsm_valid=%b, required 0", o_ltsm_valid);
    end
    i_ltsm_ready = 1'b0;
  endtask

  task automatic test_overflow();
    int ovf_seen = 0;
    int bad = 0;
    do_reset();
    for (int k = 0; k < 7; k++) begin
      i_msg_valid = 1'b1;
      i_msg_no    = 4'(k);
      i_msg_info  = 3'd1;
      i_data      = 16'h0100 + 16'(k);
      tick();
      if (o_overflow === 1'b1) ovf_seen++;
    end
    i_msg_valid = 1'b0;
    tick();
    if (o_overflow === 1'b1) ovf_seen++;
    tests++;
    if (ovf_seen != 2) begin
      fails++;
      $display("FAIL ovf_pulses: %0d, required 2", ovf_seen);
    end
    tests++;
    if (o_drop_cnt !== 8'd2) begin
      fails++;
      $display("FAIL ovf_cnt: %0d, required 2", o_drop_cnt);
    end
    i_ltsm_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      if (o_ltsm_valid !== 1'b1 || o_data !== 16'h0100 + 16'(k)) bad++;
      tick();
    end
    tests++;
    if (bad != 0 || o_ltsm_valid !== 1'b0) begin
      fails++;
      $display("FAIL ovf_drain: %0d wrong, valid=%b, required 0 wrong, valid 0", bad, o_ltsm_valid);
    end
    i_ltsm_ready = 1'b0;
  endtask

  task automatic test_parity();
    do_reset();
    i_ltsm_ready = 1'b1;
    send(4'd2, 3'd0, 16'hDEAD, 1'b1);
    tests++;
    if (o_parity_drop !== 1'b1 || o_drop_cnt !== 8'd1 || o_ltsm_valid !== 1'b0) begin
      fails++;
      $display("FAIL parity_drop: pulse=%b cnt=%0d lv=%b, required 1 1 0",
               o_parity_drop, o_drop_cnt, o_ltsm_valid);
    end
    tick();
    tests++;
    if (o_parity_drop !== 1'b0 || o_ltsm_valid !== 1'b0 || o_adp_valid !== 1'b0) begin
      fails++;
      $display("FAIL parity_after: pulse=%b lv=%b av=%b, required 0 0 0",
               o_parity_drop, o_ltsm_valid, o_adp_valid);
    end
    i_msg_valid    = 1'b1;
    i_parity_error = 1'b1;
    repeat (300) tick();
    i_msg_valid    = 1'b0;
    i_parity_error = 1'b0;
    tick();
    tests++;
    if (o_drop_cnt !== 8'd255) begin
      fails++;
      $display("FAIL cnt_saturate: %0d, required 255", o_drop_cnt);
    end
    i_ltsm_ready = 1'b0;
  endtask

  task automatic test_timeout();
    int bad = 0;
    do_reset();
`ifdef SB_RX_DISP_TIMEOUT_EN
    send(4'd2, 3'd3, 16'hCAFE, 1'b0);
    send(4'd14, 3'd4, 16'hBEEF, 1'b0);
    for (int k = 0; k < 8; k++) begin
      if (o_ltsm_valid !== 1'b1 || o_timeout !== 1'b0) bad++;
      tick();
    end
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL tmo_wait: %0d wrong cycles, required 0", bad);
    end
    tests++;
    if (o_timeout !== 1'b1 || o_ltsm_valid !== 1'b0 || o_drop_cnt !== 8'd1) begin
      fails++;
      $display("FAIL tmo_fire: pulse=%b lv=%b cnt=%0d, required 1 0 1",
               o_timeout, o_ltsm_valid, o_drop_cnt);
    end
    tick();
    tests++;
    if (o_adp_valid !== 1'b1 || o_msg_no !== 4'd14 || o_data !== 16'hBEEF || o_timeout !== 1'b0) begin
      fails++;
      $display("FAIL tmo_next: av=%b no=%0d data=%h pulse=%b, required 1 14 beef 0",
               o_adp_valid, o_msg_no, o_data, o_timeout);
    end
    i_adp_ready = 1'b1;
    tick();
    i_adp_ready = 1'b0;
`else
    send(4'd2, 3'd3, 16'hCAFE, 1'b0);
    tick();
    for (int k = 0; k < 1000; k++) begin
      if (o_ltsm_valid !== 1'b1 || o_timeout !== 1'b0) bad++;
      tick();
    end
    tests++;
    if (bad != 0 || o_drop_cnt !== 8'd0) begin
      fails++;
      $display("FAIL no_tmo_hold: %0d wrong cycles cnt=%0d, required 0 0", bad, o_drop_cnt);
    end
    i_ltsm_ready = 1'b1;
    tick();
    tests++;
    if (o_ltsm_valid !== 1'b0) begin
      fails++;
      $display("FAIL no_tmo_xfer: ltsm_valid=%b, required 0", o_ltsm_valid);
    end
    i_ltsm_ready = 1'b0;
`endif
  endtask

  task automatic test_flush_reset();
    logic [7:0] cnt_before;
    int bad = 0;
    do_reset();
    send(4'd1, 3'd0, 16'h0001, 1'b1);  // one parity drop so the count is non-zero
    for (int k = 0; k < 4; k++) send(4'(k + 4), 3'd0, 16'hF000 + 16'(k), 1'b0);
    cnt_before = o_drop_cnt;
    tests++;
    if (o_ltsm_valid !== 1'b1 || o_data !== 16'hF000 || cnt_before !== 8'd1) begin
      fails++;
      $display("FAIL flush_pre: lv=%b data=%h cnt=%0d, required 1 f000 1",
               o_ltsm_valid, o_data, cnt_before);
    end
    i_flush     = 1'b1;
    i_msg_valid = 1'b1;
    i_msg_no    = 4'd9;
    i_data      = 16'h9999;
    tick();
    i_flush     = 1'b0;
    i_msg_valid = 1'b0;
    tests++;
    if (o_ltsm_valid !== 1'b0 || o_adp_valid !== 1'b0 || o_drop_cnt !== 8'd1 || o_overflow !== 1'b0) begin
      fails++;
      $display("FAIL flush_now: lv=%b av=%b cnt=%0d ovf=%b, required 0 0 1 0",
               o_ltsm_valid, o_adp_valid, o_drop_cnt, o_overflow);
    end
    for (int k = 0; k < 3; k++) begin
      tick();
      if (o_ltsm_valid !== 1'b0 || o_adp_valid !== 1'b0) bad++;
    end
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL flush_empty: %0d cycles with valid, required 0", bad);
    end
    send(4'd7, 3'd6, 16'h7777, 1'b0);
    tick();
    tests++;
    if (o_ltsm_valid !== 1'b1 || o_msg_no !== 4'd7 || o_data !== 16'h7777) begin
      fails++;
      $display("FAIL flush_resume: lv=%b no=%0d data=%h, required 1 7 7777",
               o_ltsm_valid, o_msg_no, o_data);
    end
    // Asynchronous reset while a message is presented.
    i_rst_n = 1'b0;
    #1;
    tests++;
    if (all_outs() !== 31'd0 || o_drop_cnt !== 8'd0) begin
      fails++;
      $display("FAIL mid_reset: outs=%h cnt=%0d, required 0/0", all_outs(), o_drop_cnt);
    end
    #2 i_rst_n = 1'b1;
    tick();
    tick();
    tests++;
    if (o_ltsm_valid !== 1'b0 || o_adp_valid !== 1'b0 || o_drop_cnt !== 8'd0) begin
      fails++;
      $display("FAIL post_reset: lv=%b av=%b cnt=%0d, required 0 0 0",
               o_ltsm_valid, o_adp_valid, o_drop_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_adp_backpressure();
    test_back_to_back();
    test_overflow();
    test_parity();
    test_timeout();
    test_flush_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
